// File: rtl/blank_scheduler.sv
// blank_scheduler: sequences the physics, collision and score units once per
// frame inside the vertical blanking window of a 640x480 VGA timing chain.
// Optional watchdog on each unit's WAIT phase: define BLANK_SCHED_WDOG_EN.
module blank_scheduler #(
  parameter int VS_LINE  = 511,
  parameter int VE_LINE  = 31,
  parameter int WDOG_CYC = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        pause,
  input  logic [2:0]  done,
  output logic [2:0]  go,
  output logic        frame_tick,
  output logic        busy,
  output logic        abort,
  output logic [7:0]  overrun_cnt,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [1:0] idx_nxt;
  logic       win_open;
  logic       win_close;
  logic       wdog_hit;

  // Overrun counter sticks at its top value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Window edges are single-cycle decodes of the first pixel of a line.
  assign win_open  = (vc == 10'(VS_LINE)) && (hc == 10'd0);
  assign win_close = (vc == 10'(VE_LINE)) && (hc == 10'd0);

`ifdef BLANK_SCHED_WDOG_EN
  logic [10:0] wdog;

  // Watchdog: restarts on every ISSUE, counts while waiting for a unit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog <= 11'd0;
    end else if (state == ISSUE) begin
      wdog <= 11'd0;
    end else if (state == WAIT) begin
      wdog <= wdog + 11'd1;
    end
  end

  assign wdog_hit = (state == WAIT) && (wdog == 11'(WDOG_CYC));
`else
  // Watchdog compiled out: WAIT is left only by done or window close.
  assign wdog_hit = 1'b0 & (WDOG_CYC != 0);
`endif

  // State register and unit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state and output decode; close/watchdog abort outranks done.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    go         = 3'b000;
    frame_tick = 1'b0;
    busy       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (win_open) begin
          frame_tick = 1'b1;
          if (!pause) begin
            idx_nxt   = 2'd0;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (win_close) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          go        = 3'b001 << idx;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (win_close || wdog_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (done[idx]) begin
          if (idx == 2'd2) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Event pulses are held off while reset is asserted so counters and
    // pulses never disagree.
    frame_tick = frame_tick & rst;
    abort      = abort & rst;
  end

  // Frame and overrun statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt   <= 16'd0;
      overrun_cnt <= 8'd0;
    end else begin
      if (frame_tick) frame_cnt <= frame_cnt + 16'd1;
      if (abort) overrun_cnt <= sat_inc8(overrun_cnt);
    end
  end

endmodule

// File: tb/tb_blank_scheduler.sv
// Self-checking bench for blank_scheduler: scenario tasks plus randomized
// frames checked against an arithmetic schedule model.
module tb_blank_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        pause;
  logic [2:0]  done;
  logic [2:0]  go;
  logic        frame_tick;
  logic        busy;
  logic        abort;
  logic [7:0]  overrun_cnt;
  logic [15:0] frame_cnt;

  always #20 clk = ~clk;

  blank_scheduler #(.VS_LINE(511), .VE_LINE(31), .WDOG_CYC(2047)) dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .pause(pause), .done(done),
    .go(go), .frame_tick(frame_tick), .busy(busy), .abort(abort),
    .overrun_cnt(overrun_cnt), .frame_cnt(frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       rst_v   = 1'b0;
  logic       pause_v = 1'b0;
  logic [2:0] force_v = 3'b000;
  int         hc_n    = 0;
  int         vc_n    = 100;
  int         lat[3];
  int         due[3];

  int         log_cyc[$];
  logic [2:0] log_val[$];
  int         tick_cnt, tick_cyc, abort_cnt, abort_cyc, abort_hc, abort_vc;
  int         busy_fall_cyc;
  logic       busy_prev = 1'b0;
  logic       busy_seen;
  logic [15:0] exp_frames = 16'd0;
  int          exp_over   = 0;

  // One clock cycle: drive inputs after the rising edge, observe at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst   = rst_v;
    pause = pause_v;
    hc    = 10'(hc_n);
    vc    = 10'(vc_n);
    for (int i = 0; i < 3; i++) done[i] = force_v[i] | (cyc == due[i]);
    if (hc_n == 799) begin
      hc_n = 0;
      vc_n = (vc_n == 520) ? 0 : vc_n + 1;
    end else begin
      hc_n++;
    end
    @(negedge clk);
    if (go != 3'b000) begin
      log_cyc.push_back(cyc);
      log_val.push_back(go);
      for (int i = 0; i < 3; i++)
        if (go[i]) due[i] = (lat[i] > 0) ? cyc + lat[i] : -1;
    end
    if (frame_tick) begin tick_cnt++; tick_cyc = cyc; end
    if (abort) begin abort_cnt++; abort_cyc = cyc; abort_hc = hc; abort_vc = vc; end
    if (busy) busy_seen = 1'b1;
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic jump(input int v, input int h);
    vc_n = v;
    hc_n = h;
  endtask

  task automatic clear_obs();
    log_cyc.delete();
    log_val.delete();
    tick_cnt = 0; abort_cnt = 0; busy_seen = 1'b0; busy_fall_cyc = -1;
    for (int i = 0; i < 3; i++) due[i] = -1;
    force_v = 3'b000;
  endtask

  task automatic run_to_busy_fall(input int bound);
    for (int g = 0; g < bound && busy_fall_cyc < 0; g++) tick();
  endtask

  task automatic test_reset();
    rst_v = 1'b0;
    jump(100, 0);
    ticks(3);
    n_checks++; if (go !== 3'b000) begin n_fail++; $display("FAIL reset_go: got %b want 000", go); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", abort); end
    n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    rst_v = 1'b1;
    tick();
    exp_frames = 16'd0;
    exp_over   = 0;
  endtask

  task automatic test_nominal();
    int g0;
    clear_obs();
    lat = '{10, 10, 10};
    pause_v = 1'b0;
    jump(510, 797);
    ticks(4);
    run_to_busy_fall(200);
    exp_frames++;
    g0 = tick_cyc + 1;
    n_checks++; if (tick_cnt !== 1) begin n_fail++; $display("FAIL nom_ticks: got %0d want 1", tick_cnt); end
    n_checks++; if (log_val.size() !== 3) begin n_fail++; $display("FAIL nom_go_count: got %0d want 3", log_val.size()); end
    if (log_val.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (log_val[k] !== 3'(1 << k)) begin n_fail++; $display("FAIL nom_go_val%0d: got %b want %b", k, log_val[k], 3'(1 << k)); end
        n_checks++; if (log_cyc[k] !== g0 + 11 * k) begin n_fail++; $display("FAIL nom_go_cyc%0d: got %0d want %0d", k, log_cyc[k], g0 + 11 * k); end
      end
    end
    n_checks++; if (busy_fall_cyc - g0 !== 33) begin n_fail++; $display("FAIL nom_busy_len: got %0d want 33", busy_fall_cyc - g0); end
    n_checks++; if (overrun_cnt !== 8'(exp_over)) begin n_fail++; $display("FAIL nom_overrun: got %0d want %0d", overrun_cnt, exp_over); end
    n_checks++; if (frame_cnt !== exp_frames) begin n_fail++; $display("FAIL nom_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_pause();
    clear_obs();
    lat = '{10, 10, 10};
    pause_v = 1'b1;
    jump(511, 0);
    ticks(40);
    pause_v = 1'b0;
    exp_frames++;
    n_checks++; if (tick_cnt !== 1) begin n_fail++; $display("FAIL pause_ticks: got %0d want 1", tick_cnt); end
    n_checks++; if (log_val.size() !== 0) begin n_fail++; $display("FAIL pause_go_count: got %0d want 0", log_val.size()); end
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL pause_busy: got %b want 0", busy_seen); end
    n_checks++; if (frame_cnt !== exp_frames) begin n_fail++; $display("FAIL pause_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_done_glitch();
    int t;
    int p;
    clear_obs();
    lat = '{0, 10, 10};
    jump(511, 0);
    tick();
    t = cyc;
    force_v = 3'b001; tick();
    force_v = 3'b000; ticks(2);
    force_v = 3'b100; tick();
    force_v = 3'b000; ticks(2);
    force_v = 3'b001; tick();
    p = cyc;
    force_v = 3'b000;
    run_to_busy_fall(100);
    exp_frames++;
    n_checks++; if (log_val.size() !== 3) begin n_fail++; $display("FAIL glitch_go_count: got %0d want 3", log_val.size()); end
    if (log_val.size() == 3) begin
      n_checks++; if (log_cyc[0] !== t + 1) begin n_fail++; $display("FAIL glitch_go0_cyc: got %0d want %0d", log_cyc[0], t + 1); end
      n_checks++; if (log_val[1] !== 3'b010) begin n_fail++; $display("FAIL glitch_go1_val: got %b want 010", log_val[1]); end
      n_checks++; if (log_cyc[1] !== p + 1) begin n_fail++; $display("FAIL glitch_go1_cyc: got %0d want %0d", log_cyc[1], p + 1); end
      n_checks++; if (log_cyc[2] !== p + 12) begin n_fail++; $display("FAIL glitch_go2_cyc: got %0d want %0d", log_cyc[2], p + 12); end
    end
    n_checks++; if (busy_fall_cyc !== p + 23) begin n_fail++; $display("FAIL glitch_busy_fall: got %0d want %0d", busy_fall_cyc, p + 23); end
    n_checks++; if (frame_cnt !== exp_frames) begin n_fail++; $display("FAIL glitch_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_abort();
    int go2_seen;
    clear_obs();
    lat = '{10, 0, 10};
    jump(511, 0);
    tick();
    ticks(30);
    jump(30, 797);
    for (int g = 0; g < 10 && abort_cnt == 0; g++) tick();
    exp_frames++;
    exp_over = 1;
    go2_seen = 0;
    foreach (log_val[k]) if (log_val[k][2]) go2_seen++;
    n_checks++; if (abort_cnt !== 1) begin n_fail++; $display("FAIL abort_count: got %0d want 1", abort_cnt); end
    n_checks++; if (abort_vc !== 31 || abort_hc !== 0) begin n_fail++; $display("FAIL abort_pos: got vc=%0d hc=%0d want vc=31 hc=0", abort_vc, abort_hc); end
    n_checks++; if (go2_seen !== 0) begin n_fail++; $display("FAIL abort_go2: got %0d pulses want 0", go2_seen); end
    tick();
    n_checks++; if (overrun_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_overrun1: got %0d want 1", overrun_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    for (int f = 0; f < 299; f++) begin
      log_cyc.delete();
      log_val.delete();
      for (int i = 0; i < 3; i++) due[i] = -1;
      jump(511, 0);
      tick();
      ticks(20);
      jump(31, 0);
      ticks(2);
      exp_frames++;
      exp_over = (exp_over < 255) ? exp_over + 1 : 255;
    end
    n_checks++; if (abort_cnt !== 300) begin n_fail++; $display("FAIL abort_total: got %0d want 300", abort_cnt); end
    n_checks++; if (overrun_cnt !== 8'(exp_over)) begin n_fail++; $display("FAIL abort_saturate: got %0d want %0d", overrun_cnt, exp_over); end
    n_checks++; if (frame_cnt !== exp_frames) begin n_fail++; $display("FAIL abort_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    lat = '{3, 0, 10};
    jump(511, 0);
    tick();
    ticks(10);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
    rst_v = 1'b0; tick();
    rst_v = 1'b1; tick();
    exp_frames = 16'd0;
    exp_over   = 0;
    n_checks++; if (go !== 3'b000) begin n_fail++; $display("FAIL rmid_go: got %b want 000", go); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_checks++; if (abort !== 1'b0 || frame_tick !== 1'b0) begin n_fail++; $display("FAIL rmid_pulses: got abort=%b tick=%b want 0 0", abort, frame_tick); end
    n_checks++; if (overrun_cnt !== 8'd0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_counts: got %0d/%0d want 0/0", overrun_cnt, frame_cnt); end
    log_cyc.delete();
    log_val.delete();
    lat[1] = 10;
    ticks(50);
    n_checks++; if (log_val.size() !== 0) begin n_fail++; $display("FAIL rmid_no_go: got %0d pulses want 0", log_val.size()); end
    busy_fall_cyc = -1;
    jump(511, 0);
    tick();
    exp_frames++;
    n_checks++; if (tick_cnt !== 2) begin n_fail++; $display("FAIL rmid_tick: got %0d want 2", tick_cnt); end
    tick();
    n_checks++; if (go !== 3'b001) begin n_fail++; $display("FAIL rmid_go0: got %b want 001", go); end
    run_to_busy_fall(100);
    n_checks++; if (frame_cnt !== exp_frames) begin n_fail++; $display("FAIL rmid_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_random();
    int t, c, d, g, p, aborted;
    int e_cyc[$];
    logic [2:0] e_val[$];
    for (int f = 0; f < 20; f++) begin
      clear_obs();
      e_cyc.delete();
      e_val.delete();
      for (int i = 0; i < 3; i++) lat[i] = $urandom_range(1, 15);
      p = ($urandom_range(0, 3) == 0) ? 1 : 0;
      d = $urandom_range(10, 70);
      pause_v = p[0];
      jump(511, 0);
      tick();
      t = cyc;
      for (int k = 1; k < d; k++) begin
        pause_v = 1'($urandom_range(0, 1));
        tick();
      end
      jump(31, 0);
      tick();
      c = cyc;
      pause_v = 1'b0;
      ticks(3);
      // Schedule: go_k follows go_(k-1) by lat+1; sequence ends at t+1+sum(lat+1).
      exp_frames++;
      aborted = 0;
      if (p == 0) begin
        g = t + 1;
        for (int k = 0; k < 3; k++) begin
          if (g < c) begin e_cyc.push_back(g); e_val.push_back(3'(1 << k)); end
          g = g + lat[k] + 1;
        end
        aborted = (c < g) ? 1 : 0;
      end
      if (aborted != 0) exp_over = (exp_over < 255) ? exp_over + 1 : 255;
      n_checks++; if (log_val.size() !== e_val.size()) begin n_fail++; $display("FAIL rnd%0d_go_count: got %0d want %0d", f, log_val.size(), e_val.size()); end
      if (log_val.size() == e_val.size()) begin
        foreach (e_val[k]) begin
          n_checks++; if (log_val[k] !== e_val[k] || log_cyc[k] !== e_cyc[k]) begin n_fail++; $display("FAIL rnd%0d_go%0d: got %b@%0d want %b@%0d", f, k, log_val[k], log_cyc[k], e_val[k], e_cyc[k]); end
        end
      end
      n_checks++; if (abort_cnt !== aborted) begin n_fail++; $display("FAIL rnd%0d_abort: got %0d want %0d", f, abort_cnt, aborted); end
      if (aborted != 0) begin
        n_checks++; if (abort_cyc !== c) begin n_fail++; $display("FAIL rnd%0d_abort_cyc: got %0d want %0d", f, abort_cyc, c); end
      end
      n_checks++; if (overrun_cnt !== 8'(exp_over)) begin n_fail++; $display("FAIL rnd%0d_overrun: got %0d want %0d", f, overrun_cnt, exp_over); end
      n_checks++; if (frame_cnt !== exp_frames) begin n_fail++; $display("FAIL rnd%0d_frame_cnt: got %0d want %0d", f, frame_cnt, exp_frames); end
    end
  endtask

`ifdef BLANK_SCHED_WDOG_EN
  task automatic test_wdog();
    int t;
    clear_obs();
    lat = '{0, 10, 10};
    jump(511, 0);
    tick();
    t = cyc;
    for (int g = 0; g < 2200 && abort_cnt == 0; g++) tick();
    tick();
    exp_frames++;
    exp_over = (exp_over < 255) ? exp_over + 1 : 255;
    n_checks++; if (abort_cyc !== t + 2049) begin n_fail++; $display("FAIL wdog_abort_cyc: got %0d want %0d", abort_cyc, t + 2049); end
    n_checks++; if (overrun_cnt !== 8'(exp_over)) begin n_fail++; $display("FAIL wdog_overrun: got %0d want %0d", overrun_cnt, exp_over); end
    n_checks++; if (log_val.size() !== 1) begin n_fail++; $display("FAIL wdog_go_count: got %0d want 1", log_val.size()); end
  endtask
`endif

  initial begin
    rst = 1'b0; hc = 10'd0; vc = 10'd100; pause = 1'b0; done = 3'b000;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; due[i] = -1; end
    test_reset();
    test_nominal();
    test_pause();
    test_done_glitch();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef BLANK_SCHED_WDOG_EN
    test_wdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
